// File: rtl/spi_frame_receiver.sv
// SPI slave receive path: pin synchronisers, word assembly, command/payload
// framing and an output FIFO presented as a valid/ready stream.
module spi_frame_receiver #(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] len_cmd,
  input  logic [LEN_W-1:0]  len_value,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_is_cmd,
  output logic [DATA_W-1:0] m_cmd,
  output logic [LEN_W-1:0]  m_index,
  output logic              overflow,
  output logic              frame_abort,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = FIFO_DEPTH[PTR_W:0];
  // Modes 0 and 3 sample on a rising SCK edge, modes 1 and 2 on a falling one.
  localparam bit SAMPLE_LEVEL = ~(CPOL ^ CPHA);

  typedef enum logic {ST_CMD, ST_PAYLOAD} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_s, sck_s, mosi_s, sample_edge;
  logic [DATA_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   word_done_q, word_done_d;
  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      cmd_q, cmd_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic                   frame_abort_q, frame_abort_d;
  logic                   overflow_q, overflow_d;
  logic                   last_payload;
  logic                   ent_is_cmd;
  logic [DATA_W-1:0]      ent_cmd;
  logic [LEN_W-1:0]       ent_idx;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic                   full, push, pop;
  logic [DATA_W-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      fifo_data_d [FIFO_DEPTH];
  logic [DATA_W-1:0]      fifo_cmd_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]      fifo_cmd_d  [FIFO_DEPTH];
  logic [LEN_W-1:0]       fifo_idx_q  [FIFO_DEPTH];
  logic [LEN_W-1:0]       fifo_idx_d  [FIFO_DEPTH];
  logic                   fifo_isc_q  [FIFO_DEPTH];
  logic                   fifo_isc_d  [FIFO_DEPTH];

  assign cs_s         = cs_sync_q[SYNC_STAGES-1];
  assign sck_s        = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
  assign sample_edge  = !cs_s && (sck_s != sck_prev_q) && (sck_s == SAMPLE_LEVEL);
  assign last_payload = (idx_q == remaining_q - LEN_W'(1));

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d  = sck_s;
  end

  // Deselect throws away any partial word; a full word flags the parser next cycle.
  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = 1'b0;
    if (cs_s) begin
      bit_cnt_d = '0;
    end else if (sample_edge) begin
      sr_d = MSB_FIRST ? {sr_q[DATA_W-2:0], mosi_s} : {mosi_s, sr_q[DATA_W-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d   = '0;
        word_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (word_done_q) begin
      case (state_q)
        ST_CMD:     if (len_value != '0) state_d = ST_PAYLOAD;
        ST_PAYLOAD: if (last_payload)    state_d = ST_CMD;
        default:    state_d = ST_CMD;
      endcase
    end
    if (cs_s) state_d = ST_CMD;
  end

  always_comb begin
    ent_is_cmd    = (state_q == ST_CMD);
    ent_cmd       = ent_is_cmd ? sr_q : cmd_q;
    ent_idx       = ent_is_cmd ? '0 : idx_q;
    cmd_d         = cmd_q;
    remaining_d   = remaining_q;
    idx_d         = idx_q;
    frame_abort_d = cs_s && ((bit_cnt_q != '0) || (state_q == ST_PAYLOAD));
    if (word_done_q) begin
      if (state_q == ST_CMD) begin
        cmd_d       = sr_q;
        remaining_d = len_value;
        idx_d       = '0;
      end else if (!last_payload) begin
        idx_d = idx_q + LEN_W'(1);
      end
    end
  end

  // A word finding the FIFO full is dropped unless the consumer pops in the same cycle.
  assign pop  = m_valid && m_ready;
  assign full = (count_q == FULL_COUNT);
  assign push = word_done_q && (!full || pop);

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_cmd_d  = fifo_cmd_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_isc_d  = fifo_isc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q || (word_done_q && full && !pop);
    if (push) begin
      fifo_data_d[wr_ptr_q] = sr_q;
      fifo_cmd_d[wr_ptr_q]  = ent_cmd;
      fifo_idx_d[wr_ptr_q]  = ent_idx;
      fifo_isc_d[wr_ptr_q]  = ent_is_cmd;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    fifo_data_q <= fifo_data_d;
    fifo_cmd_q  <= fifo_cmd_d;
    fifo_idx_q  <= fifo_idx_d;
    fifo_isc_q  <= fifo_isc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync_q     <= '1;
      sck_sync_q    <= {SYNC_STAGES{CPOL}};
      mosi_sync_q   <= '0;
      sck_prev_q    <= CPOL;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      word_done_q   <= 1'b0;
      cmd_q         <= '0;
      remaining_q   <= '0;
      idx_q         <= '0;
      frame_abort_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_prev_q    <= sck_prev_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      word_done_q   <= word_done_d;
      cmd_q         <= cmd_d;
      remaining_q   <= remaining_d;
      idx_q         <= idx_d;
      frame_abort_q <= frame_abort_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Empty FIFO presents zeros rather than stale storage.
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_cmd       = m_valid ? fifo_cmd_q[rd_ptr_q]  : '0;
  assign m_index     = m_valid ? fifo_idx_q[rd_ptr_q]  : '0;
  assign m_is_cmd    = m_valid ? fifo_isc_q[rd_ptr_q]  : 1'b0;
  assign len_cmd     = sr_q;
  assign busy        = !cs_s;
  assign overflow    = overflow_q;
  assign frame_abort = frame_abort_q;

endmodule
